// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: EX-stage multiply/divide sequencer that owns the HI/LO write bus.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module hilo_mdu_ctrl #(
    parameter int unsigned ITER        = 32,
    parameter logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_stall,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stallreq_for_ex,
    output logic        busy,
    output logic [65:0] hilo_ex_to_mem_bus
);

    localparam int unsigned     CntW    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     acc_q, acc_d;
    logic [31:0]     opnd_q, opnd_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;

    logic        is_mul, is_div, is_signed, div_zero, neg_start;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        is_mul    = start && ((op == OpMult) || (op == OpMultu));
        is_div    = start && ((op == OpDiv) || (op == OpDivu));
        is_signed = (op == OpMult) || (op == OpDiv);
        mag_a     = (is_signed && src_a[31]) ? -src_a : src_a;
        mag_b     = (is_signed && src_b[31]) ? -src_b : src_b;
        div_zero  = is_div && (src_b == 32'd0);
        neg_start = is_signed && (src_a[31] ^ src_b[31]);
    end

`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'b0, mag_a} * {32'b0, mag_b};
`endif

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial, div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] fin_raw, fin_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_trial = {acc_q[63:32], acc_q[31]};
        div_diff  = div_trial - {1'b0, opnd_q};
        // Remainder stays below the divisor, so bit 32 of the difference is exactly the borrow.
        div_ge    = ~div_diff[32];
        div_rem   = div_ge ? div_diff[31:0] : div_trial[31:0];
        div_next  = {div_rem, acc_q[30:0], div_ge};
        fin_raw   = (state_q == StMul) ? mul_next : div_next;
        if (state_q == StMul) begin
            fin_fix = neg_res_q ? -fin_raw : fin_raw;
        end else begin
            fin_fix = {(neg_rem_q ? -fin_raw[63:32] : fin_raw[63:32]),
                       (neg_res_q ? -fin_raw[31:0] : fin_raw[31:0])};
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        acc_d              = acc_q;
        opnd_d             = opnd_q;
        neg_res_d          = neg_res_q;
        neg_rem_d          = neg_rem_q;
        stallreq_for_ex    = 1'b0;
        hilo_ex_to_mem_bus = 66'b0;

        unique case (state_q)
            StIdle: begin
                stallreq_for_ex = is_mul || is_div;
                if (div_zero) begin
                    state_d = StDone;
                    acc_d   = {src_a, DIV_ZERO_LO};
                end else if (is_div) begin
                    state_d   = StDiv;
                    cnt_d     = '0;
                    acc_d     = {32'b0, mag_a};
                    opnd_d    = mag_b;
                    neg_res_d = neg_start;
                    neg_rem_d = is_signed && src_a[31];
                end else if (is_mul) begin
`ifdef MDU_FAST_MUL_EN
                    state_d = StDone;
                    acc_d   = neg_start ? -fast_prod : fast_prod;
`else
                    state_d   = StMul;
                    cnt_d     = '0;
                    acc_d     = {32'b0, mag_b};
                    opnd_d    = mag_a;
                    neg_res_d = neg_start;
                    neg_rem_d = 1'b0;
`endif
                end else if (start && (op == OpMthi)) begin
                    hilo_ex_to_mem_bus = {src_a, 32'b0, 2'b10};
                end else if (start && (op == OpMtlo)) begin
                    hilo_ex_to_mem_bus = {32'b0, src_a, 2'b01};
                end
            end
            StMul, StDiv: begin
                stallreq_for_ex = 1'b1;
                cnt_d           = cnt_q + CntW'(1);
                acc_d           = (state_q == StMul) ? mul_next : div_next;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    acc_d   = fin_fix;
                end
            end
            StDone: begin
                hilo_ex_to_mem_bus = {acc_q, 2'b11};
                if (!ex_stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset is gated here too so a result sitting in DONE cannot escape in the reset cycle.
        if (rst || flush) begin
            state_d                 = StIdle;
            cnt_d                   = '0;
            stallreq_for_ex         = 1'b0;
            hilo_ex_to_mem_bus[1:0] = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy = (state_q == StMul) || (state_q == StDiv);

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: randomized mul/div/mthi/mtlo stimulus checked against an arithmetic model.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_hilo_mdu_ctrl;

`ifdef MDU_FAST_MUL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif
    localparam int Iter = 32;

    logic        clk = 1'b0;
    logic        rst, flush, ex_stall, start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        stallreq_for_ex, busy;
    logic [65:0] bus;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_mdu_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .ex_stall           (ex_stall),
        .start              (start),
        .op                 (op),
        .src_a              (src_a),
        .src_b              (src_b),
        .stallreq_for_ex    (stallreq_for_ex),
        .busy               (busy),
        .hilo_ex_to_mem_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected HI/LO result straight from the arithmetic definition of each op.
    function automatic logic [65:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] t, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: t = sa * sb;
            3'd2: t = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    t = {a, 32'hFFFFFFFF};
                end else if (o == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                    t = {r[31:0], q[31:0]};
                end else begin
                    t = {a % b, a / b};
                end
            end
        endcase
        return {t, 2'b11};
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit stall_all);
        logic [65:0] exp;
        int          exp_done, n, stall_cnt, k;
        bit          done, prev_ex;
        exp      = model(o, a, b);
        exp_done = ((o >= 3'd3) && (b == 32'd0)) || ((o <= 3'd2) && Fast) ? 1 : Iter + 1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b1; op = o; src_a = a; src_b = b;
        ex_stall = stall_all ? 1'b1 : 1'($urandom_range(0, 1));
        check("start_idle", 66'(busy), 66'd0);
        n = 0; stall_cnt = 0; done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (bus[1:0] == 2'b11) begin
                done = 1'b1;
            end else begin
                if (stallreq_for_ex) stall_cnt++;
                n++;
                @(posedge clk); #1;
                ex_stall = stall_all ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        check("done_cycle", 66'(n), 66'(exp_done));
        check("stall_cycles", 66'(stall_cnt), 66'(exp_done));
        check("result", bus, exp);
        check("done_nostall", {64'd0, busy, stallreq_for_ex}, 66'd0);
        prev_ex = ex_stall;
        k = 0;
        while (prev_ex && k < 10) begin
            @(posedge clk); #1;
            ex_stall = (k < hold);
            k++;
            @(negedge clk);
            check("done_hold", bus, exp);
            check("hold_nostall", {64'd0, busy, stallreq_for_ex}, 66'd0);
            prev_ex = ex_stall;
        end
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; ex_stall = 1'b0;
        @(negedge clk);
        check("back_idle", {bus[65:2], busy, stallreq_for_ex}, 66'd0);
    endtask

    task automatic do_single(input logic [2:0] o, input logic [31:0] a);
        logic [65:0] exp;
        exp = (o == 3'd5) ? {a, 32'b0, 2'b10} : (o == 3'd6) ? {32'b0, a, 2'b01} : 66'd0;
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = $urandom;
        ex_stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("single_bus", bus, exp);
        check("single_stall", {64'd0, busy, stallreq_for_ex}, 66'd0);
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("single_after", {bus, busy}, 67'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; start = 1'b0;
        op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {bus[65:2], busy, stallreq_for_ex}, 66'd0);
        check("reset_we", 66'(bus[1:0]), 66'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", {bus, busy, stallreq_for_ex}, 68'd0);

        do_op(3'd1, 32'hFFFFFFFD, 32'd5, 0, 1'b0);
        do_op(3'd4, 32'd100, 32'd7, 3, 1'b1);
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1, 1'b0);
        do_op(3'd3, 32'h12345678, 32'd0, 2, 1'b1);
        do_single(3'd5, 32'hDEADBEEF);
        do_single(3'd6, 32'h0BADF00D);
        do_single(3'd0, 32'h11111111);
        do_single(3'd7, 32'h22222222);

        // Flush a MULTU at cycle 10, then launch a DIVU straight after.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd2; src_a = $urandom; src_b = $urandom; ex_stall = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy", 66'(busy), Fast ? 66'd0 : 66'd1);
        check("flush_stall", 66'(stallreq_for_ex), 66'd0);
        check("flush_we", 66'(bus[1:0]), 66'd0);
        do_op(3'd4, 32'd1000, 32'd13, 1, 1'b0);

        // Reset while a result sits in DONE must not leak a write.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd4; src_a = 32'd5; src_b = 32'd0; ex_stall = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_done_we", {64'd0, bus[1:0]}, 66'd0);
        check("rst_done_stall", 66'(stallreq_for_ex), 66'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; op = 3'd0; ex_stall = 1'b0;
        @(negedge clk);
        check("rst_done_idle", {bus, busy}, 67'd0);

        // Reset mid-divide.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {64'd0, bus[1:0]} | 66'(stallreq_for_ex), 66'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("rst_mid_idle", {bus, busy}, 67'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = $urandom_range(1, 20);
                default: ;
            endcase
            do_op(o, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                do_single(3'($urandom_range(5, 6)), $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
